// File: rtl/bsg_wormhole_mem_arb_pkg.sv
// bsg_wormhole_mem_arb_pkg: FSM state types and wormhole header field offsets (cord at LSB, then len, then cid)
package bsg_wormhole_mem_arb_pkg;
  typedef enum logic {REQ_IDLE, REQ_BUSY} req_state_e;
  typedef enum logic {RESP_IDLE, RESP_BUSY} resp_state_e;
  function automatic int len_lsb(input int cord_w);
    return cord_w;
  endfunction
  function automatic int cid_lsb(input int cord_w, input int len_w);
    return cord_w + len_w;
  endfunction
endpackage

// File: rtl/bsg_wormhole_pkt_len_tracker.sv
// bsg_wormhole_pkt_len_tracker: counts remaining body flits of a wormhole packet; busy_o is the in-packet flag for the next cycle
module bsg_wormhole_pkt_len_tracker #(
  parameter int len_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   hdr_i,
  input  logic                   hs_i,
  input  logic [len_width_p-1:0] len_i,
  output logic                   busy_o,
  output logic                   last_o
);
  logic [len_width_p-1:0] cnt_q, cnt_d;
  always_comb begin
    last_o = hdr_i ? (len_i == '0) : (cnt_q == len_width_p'(1));
    busy_o = hs_i ? ~last_o : ~hdr_i;
    cnt_d  = hs_i ? (hdr_i ? len_i : cnt_q - len_width_p'(1)) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bsg_wormhole_mem_arbiter.sv
// bsg_wormhole_mem_arbiter: packet-granular 2:1 wormhole memory arbiter; per-port grant counters enabled by BSG_WH_MEM_ARB_STATS_EN
module bsg_wormhole_mem_arbiter
  import bsg_wormhole_mem_arb_pkg::*;
#(
  parameter int wh_flit_width_p = 32,
  parameter int wh_cord_width_p = 7,
  parameter int wh_len_width_p  = 4,
  parameter int wh_cid_width_p  = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [1:0]                      req_v_i,
  input  logic [1:0][wh_flit_width_p-1:0] req_data_i,
  output logic [1:0]                      req_ready_and_o,
  output logic                            mem_req_v_o,
  output logic [wh_flit_width_p-1:0]      mem_req_data_o,
  input  logic                            mem_req_ready_and_i,
  input  logic                            mem_resp_v_i,
  input  logic [wh_flit_width_p-1:0]      mem_resp_data_i,
  output logic                            mem_resp_ready_and_o,
  output logic [1:0]                      resp_v_o,
  output logic [1:0][wh_flit_width_p-1:0] resp_data_o,
  input  logic [1:0]                      resp_ready_and_i,
  output logic [1:0][31:0]                pkt_count_o
);
  localparam int len_lsb_lp = len_lsb(wh_cord_width_p);
  localparam int cid_lsb_lp = cid_lsb(wh_cord_width_p, wh_len_width_p);

  req_state_e  req_state_q, req_state_d;
  resp_state_e resp_state_q, resp_state_d;
  logic rr_q, rr_d, req_sel_q, req_sel_d, resp_sel_q, resp_sel_d;
  logic req_hdr, req_win, req_sel, req_hs, req_busy, req_last;
  logic resp_hdr, resp_sel, resp_hs, resp_busy, resp_last;

  assign req_hdr  = req_state_q == REQ_IDLE;
  assign req_win  = req_v_i[rr_q] ? rr_q : ~rr_q;
  assign req_sel  = req_hdr ? req_win : req_sel_q;
  assign req_hs   = mem_req_v_o & mem_req_ready_and_i;
  assign resp_hdr = resp_state_q == RESP_IDLE;
  assign resp_sel = resp_hdr ? mem_resp_data_i[cid_lsb_lp] : resp_sel_q;
  assign resp_hs  = mem_resp_v_i & mem_resp_ready_and_o;

  bsg_wormhole_pkt_len_tracker #(.len_width_p(wh_len_width_p)) req_trk (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .hdr_i  (req_hdr),
    .hs_i   (req_hs),
    .len_i  (req_data_i[req_sel][len_lsb_lp +: wh_len_width_p]),
    .busy_o (req_busy),
    .last_o (req_last)
  );

  bsg_wormhole_pkt_len_tracker #(.len_width_p(wh_len_width_p)) resp_trk (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .hdr_i  (resp_hdr),
    .hs_i   (resp_hs),
    .len_i  (mem_resp_data_i[len_lsb_lp +: wh_len_width_p]),
    .busy_o (resp_busy),
    .last_o (resp_last)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_state_q  <= REQ_IDLE;
      resp_state_q <= RESP_IDLE;
      rr_q         <= 1'b0;
      req_sel_q    <= 1'b0;
      resp_sel_q   <= 1'b0;
    end else begin
      req_state_q  <= req_state_d;
      resp_state_q <= resp_state_d;
      rr_q         <= rr_d;
      req_sel_q    <= req_sel_d;
      resp_sel_q   <= resp_sel_d;
    end
  end

  always_comb begin
    req_state_d  = req_busy ? REQ_BUSY : REQ_IDLE;
    resp_state_d = resp_busy ? RESP_BUSY : RESP_IDLE;
    rr_d         = (req_hs & req_last) ? ~req_sel : rr_q;
    req_sel_d    = (req_hs & req_hdr) ? req_win : req_sel_q;
    resp_sel_d   = (resp_hs & resp_hdr) ? resp_sel : resp_sel_q;
  end

  always_comb begin
    mem_req_v_o     = ~reset_i & req_v_i[req_sel];
    mem_req_data_o  = req_data_i[req_sel];
    if (req_hdr) mem_req_data_o[cid_lsb_lp +: wh_cid_width_p] = wh_cid_width_p'(req_win);
    req_ready_and_o = {2{~reset_i & mem_req_ready_and_i}} & (req_sel ? 2'b10 : 2'b01);
    resp_v_o        = {2{~reset_i & mem_resp_v_i}} & (resp_sel ? 2'b10 : 2'b01);
    resp_data_o     = {2{mem_resp_data_i}};
    mem_resp_ready_and_o = ~reset_i & resp_ready_and_i[resp_sel];
  end

`ifdef BSG_WH_MEM_ARB_STATS_EN
  logic [1:0][31:0] pkt_count_q, pkt_count_d;
  always_comb begin
    pkt_count_d = pkt_count_q;
    if (req_hs && req_hdr) pkt_count_d[req_win] = pkt_count_q[req_win] + 32'd1;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) pkt_count_q <= '0;
    else         pkt_count_q <= pkt_count_d;
  end
  assign pkt_count_o = pkt_count_q;
`else
  assign pkt_count_o = '0;
`endif
endmodule

// File: tb/tb_bsg_wormhole_mem_arbiter.sv
// tb_bsg_wormhole_mem_arbiter: directed literal checks plus randomized traffic against a packet-queue reference model
module tb_bsg_wormhole_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_v, req_rdy, resp_v, resp_rdy;
  logic [1:0][31:0] req_data, resp_data, pkt_count;
  logic mem_req_v, mem_req_rdy, mem_resp_v, mem_resp_rdy;
  logic [31:0] mem_req_data, mem_resp_data;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bsg_wormhole_mem_arbiter dut (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(req_v), .req_data_i(req_data), .req_ready_and_o(req_rdy),
    .mem_req_v_o(mem_req_v), .mem_req_data_o(mem_req_data), .mem_req_ready_and_i(mem_req_rdy),
    .mem_resp_v_i(mem_resp_v), .mem_resp_data_i(mem_resp_data), .mem_resp_ready_and_o(mem_resp_rdy),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_ready_and_i(resp_rdy),
    .pkt_count_o(pkt_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] exp_cnt(input longint n, input longint s);
`ifdef BSG_WH_MEM_ARB_STATS_EN
    return {s[31:0], n[31:0]};
`else
    return 64'd0;
`endif
  endfunction

  // reference model state: packet queues per source, flits left in the open packet, owner, priority
  logic [31:0] qr[2][$];
  logic [31:0] qs[$];
  int rem, own, rr, srem, sown;
  longint cnt[2];

  function automatic logic [31:0] mk_hdr(input int len, input int cid);
    logic [31:0] h;
    h = $urandom;
    h[10:7] = len[3:0];
    h[11] = cid[0];
    return h;
  endfunction

  task automatic gen_pkt(input int dst);
    int len;
    len = ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 3);
    if (dst < 2) qr[dst].push_back(mk_hdr(len, $urandom_range(0, 1)));
    else qs.push_back(mk_hdr(len, $urandom_range(0, 1)));
    for (int k = 0; k < len; k++) begin
      if (dst < 2) qr[dst].push_back($urandom);
      else qs.push_back($urandom);
    end
  endtask

  initial begin
    reset = 1'b1; req_v = 2'b11;
    req_data[0] = 32'hABC00985; req_data[1] = 32'h55500002;
    mem_req_rdy = 1'b1; mem_resp_v = 1'b1; mem_resp_data = 32'h0; resp_rdy = 2'b11;
    repeat (4) begin
      @(negedge clk); #1;
      chk("rst_mem_req_v", mem_req_v, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_v", resp_v, 0);
      chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
      chk("rst_pkt_count", pkt_count, 0);
    end
    @(negedge clk); reset = 1'b0; mem_resp_v = 1'b0; #1;
    chk("n_hdr_v", mem_req_v, 1);
    chk("n_hdr_data", mem_req_data, 32'hABC00185);
    chk("n_hdr_rdy", req_rdy, 2'b01);
    @(negedge clk); req_data[0] = 32'h11111111; #1;
    chk("n_d1_data", mem_req_data, 32'h11111111);
    chk("n_d1_rdy", req_rdy, 2'b01);
    @(negedge clk); req_data[0] = 32'h22222222; mem_req_rdy = 1'b0;
    repeat (5) begin
      #1;
      chk("stall_rdy", req_rdy, 2'b00);
      chk("stall_data", mem_req_data, 32'h22222222);
      @(negedge clk);
    end
    mem_req_rdy = 1'b1; #1;
    chk("n_d2_data", mem_req_data, 32'h22222222);
    chk("n_d2_rdy", req_rdy, 2'b01);
    @(negedge clk); req_data[0] = 32'h33333333; #1;
    chk("n_d3_data", mem_req_data, 32'h33333333);
    chk("n_d3_rdy", req_rdy, 2'b01);
    @(negedge clk); req_data[0] = 32'h00000801; #1;
    chk("s_hdr_data", mem_req_data, 32'h55500802);
    chk("s_hdr_rdy", req_rdy, 2'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("alt_data", mem_req_data, (k % 2 == 0) ? 32'h00000001 : 32'h55500802);
      chk("alt_rdy", req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(negedge clk); req_v = 2'b00; #1;
    chk("dir_pkt_count", pkt_count, exp_cnt(3, 3));
    @(negedge clk); mem_resp_v = 1'b1; mem_resp_data = 32'h00000900; #1;
    chk("rsp_hdr_v", resp_v, 2'b10);
    chk("rsp_hdr_data", resp_data[1], 32'h00000900);
    chk("rsp_hdr_rdy", mem_resp_rdy, 1);
    @(negedge clk); mem_resp_data = 32'h00000000; #1;
    chk("rsp_d1_v", resp_v, 2'b10);
    @(negedge clk); mem_resp_data = 32'hFFFFF7FF; resp_rdy = 2'b01; #1;
    chk("rsp_bp_rdy", mem_resp_rdy, 0);
    chk("rsp_bp_v", resp_v, 2'b10);
    @(negedge clk); resp_rdy = 2'b11; #1;
    chk("rsp_d2_rdy", mem_resp_rdy, 1);
    chk("rsp_d2_data", resp_data[1], 32'hFFFFF7FF);
    @(negedge clk); mem_resp_data = 32'h00000000; #1;
    chk("rsp_hdr0_v", resp_v, 2'b01);
    @(negedge clk); mem_resp_v = 1'b0; req_v = 2'b01; req_data[0] = 32'h00000100; #1;
    chk("abort_hdr_v", mem_req_v, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; req_data[0] = 32'hFFFFFFFF; #1;
    chk("abort_rehdr", mem_req_data, 32'hFFFFF7FF);
    chk("abort_pkt_count", pkt_count, 0);
    @(negedge clk); reset = 1'b1; req_v = 2'b00;
    @(negedge clk);
    rem = 0; own = 0; rr = 0; srem = 0; sown = 0; cnt[0] = 0; cnt[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] f;
      logic [1:0] er;
      int sel, rsel;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (qr[i].size() == 0) gen_pkt(i);
        req_v[i] = $urandom_range(0, 3) != 0;
        req_data[i] = qr[i][0];
      end
      mem_req_rdy = $urandom_range(0, 3) != 0;
      if (qs.size() == 0) gen_pkt(2);
      mem_resp_v = $urandom_range(0, 2) != 0;
      mem_resp_data = qs[0];
      resp_rdy = 2'($urandom_range(0, 3));
      #1;
      sel = (rem != 0) ? own : (req_v[rr] ? rr : 1 - rr);
      f = qr[sel][0];
      if (rem == 0) f[11] = sel[0];
      chk("rnd_mem_req_v", mem_req_v, req_v[sel]);
      if (req_v[sel]) chk("rnd_mem_req_data", mem_req_data, f);
      er = 2'b00;
      er[sel] = mem_req_rdy;
      if (rem != 0 || req_v != 2'b00) chk("rnd_req_rdy", req_rdy, er);
      if (req_v[sel] && mem_req_rdy) begin
        f = qr[sel].pop_front();
        if (rem == 0) begin
          cnt[sel]++;
          rem = int'(f[10:7]);
          own = sel;
          if (rem == 0) rr = 1 - sel;
        end else begin
          rem--;
          if (rem == 0) rr = 1 - own;
        end
      end
      rsel = (srem != 0) ? sown : int'(qs[0][11]);
      er = 2'b00;
      er[rsel] = mem_resp_v;
      chk("rnd_resp_v", resp_v, er);
      if (mem_resp_v) chk("rnd_resp_data", resp_data[rsel], qs[0]);
      chk("rnd_mem_resp_rdy", mem_resp_rdy, resp_rdy[rsel]);
      if (mem_resp_v && resp_rdy[rsel]) begin
        f = qs.pop_front();
        if (srem == 0) begin
          srem = int'(f[10:7]);
          sown = rsel;
        end else srem--;
      end
      chk("rnd_pkt_count", pkt_count, exp_cnt(cnt[0], cnt[1]));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bsg_wormhole_mem_arbiter.md
# bsg_wormhole_mem_arbiter

Packet-granular 2:1 arbiter that lets the north and south vcache wormhole links of a pod share one wormhole memory endpoint, e.g. a single `bsg_nonsynth_wormhole_test_mem` or DRAM controller port. Request packets are merged onto one outbound link. The cid field of each forwarded header is rewritten with the source port index. Response packets are steered back to the correct side by that cid. It sits between the pod's `wh_link_sif_lo[N|S][E]` ports and the memory model, in the testbench and in chip-level memory paths.

## Interface
- `wh_flit_width_p`, default 32: flit width in bits.
- `wh_cord_width_p`, default 7: cord field width; the cord field occupies bits [cord-1:0] of the header.
- `wh_len_width_p`, default 4: len field width, directly above cord.
- `wh_cid_width_p`, default 1: cid field width, directly above len; must be ≥1.
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: reset; synchronous, active-high.
- `req_v_i` / `req_data_i` / `req_ready_and_o`, in / in / out, [1:0] / [1:0][flit] / [1:0]: request links from the pod. Index 0 = north, 1 = south.
- `mem_req_v_o` / `mem_req_data_o` / `mem_req_ready_and_i`, out / out / in, 1 / flit / 1: merged request link to memory.
- `mem_resp_v_i` / `mem_resp_data_i` / `mem_resp_ready_and_o`, in / in / out, 1 / flit / 1: response link from memory.
- `resp_v_o` / `resp_data_o` / `resp_ready_and_i`, out / out / in, [1:0] / [1:0][flit] / [1:0]: response links to the pod.
- `pkt_count_o`, out, [1:0][31:0]: requests granted per port. Only populated with the stats macro; see Configuration.

## Operation
- Ready/valid handshake: a transfer happens when v and ready_and are both high in the same cycle. The block has no flit storage; it is pure steering plus control state.
- **Request FSM** has two states, `REQ_IDLE` and `REQ_BUSY`.
  - In `REQ_IDLE`, a round-robin arbiter picks a winner among ports with `req_v_i` high. Priority pointer `rr_r` resets to 0, i.e. north has priority.
  - The winner's header is forwarded combinationally, with the cid field replaced by the winner index zero-extended to cid width. The winner's `req_ready_and_o` equals `mem_req_ready_and_i`; the loser's is 0.
  - When the header handshakes with len = 0, the packet completes and the FSM stays in `REQ_IDLE`.
  - When the header handshakes with len > 0, `req_cnt_r` is loaded with len, `req_sel_r` is set to the winner, and the FSM moves to `REQ_BUSY`.
  - In `REQ_BUSY`, only `req_sel_r` is connected and data flits pass unmodified. Each handshake decrements `req_cnt_r`. The handshake made with `req_cnt_r` = 1 returns the FSM to `REQ_IDLE`.
  - On packet completion, `rr_r` is set to the opposite of the port just served.
- **Response FSM** has two states, `RESP_IDLE` and `RESP_BUSY`.
  - In `RESP_IDLE`, the output is selected by the LSB of the incoming header's cid. The header is forwarded unmodified only to that port, and `mem_resp_ready_and_o` follows that port's `resp_ready_and_i`.
  - The len handling, counter (`resp_cnt_r`, `resp_sel_r`) and return to idle mirror the request FSM.
- The two FSMs are fully independent; request and response traffic flow concurrently.

## Timing
- Request and response paths both have zero-cycle latency (combinational v, data and ready paths). Grant decisions are registered only at packet boundaries.
- Reset values:
  - FSM states: `REQ_IDLE` / `RESP_IDLE`.
  - Counters, `rr_r` and select registers: 0.
  - Outputs: `mem_req_v_o`=0, `resp_v_o`=0, `req_ready_and_o`=0, `mem_resp_ready_and_o`=0 while reset is high, and `pkt_count_o`=0.
- Both ports valid in `REQ_IDLE` → `rr_r` decides. A waiting port is served within one packet.
- Winner valid but memory not ready → grant stays combinational and is not locked. A different port may win next cycle if `rr_r` has not changed; `rr_r` only changes on completion.
- Stalls mid-packet (v or ready low) hold the counters and never release the lock.
- Reset mid-packet aborts the packet: counters clear and the FSMs return to idle. Partial packets are not recovered.
- Counter width is `wh_len_width_p`; len = 2^len_width−1 is legal.

## Configuration
- `BSG_WH_MEM_ARB_STATS_EN` defined:
  - `pkt_count_o[i]` increments on each header handshake granted to port i.
  - The counter wraps at 2^32.
- Macro undefined: `pkt_count_o` is tied to 0 and no counter flops exist.

## Structure
- A shared package `bsg_wormhole_mem_arb_pkg` holds:
  - the FSM enum types `req_state_e` and `resp_state_e`;
  - a parameterized header-field-offset convention: cord LSB, then len, then cid.
- One natural sub-module, `bsg_wormhole_pkt_len_tracker`. It takes the header-v / len / handshake inputs and produces a busy flag and last-flit flag. It is instantiated once for requests and once for responses.

## Test plan
- Reset for 4 cycles with `req_v_i`=2'b11 → all v/ready outputs stay 0 during reset. After reset, north wins first.
- North sends a len=3 packet with cid=1 in its header while south holds `req_v_i` → 4 flits appear on memory with cid rewritten to 0. South is blocked until the 4th handshake, then its header appears on the next accepted cycle.
- Both ports continuously send len=0 packets → grants alternate N,S,N,S on consecutive handshakes.
- Memory drops `mem_req_ready_and_i` for 5 cycles mid-packet → `req_cnt_r` holds. After ready returns, the remaining flits pass and there is no interleaving.
- Response header with cid=1 and len=2 → 3 flits appear only on `resp_v_o[1]`. South back-pressure also stalls `mem_resp_ready_and_o`.
- With `BSG_WH_MEM_ARB_STATS_EN`: after 7 north and 3 south packets → `pkt_count_o` = {3,7}. Without the macro → `pkt_count_o` = 0.
